// File: rtl/xorshift32_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xorshift32_checker                                                       |
// | Self-synchronising checker for an xorshift32 word stream with lock and   |
// | saturating error/word counters. Option: XORSHIFT32_CHECKER_SEED_EN       |
// | (adds a seed port; the predictor starts from next(seed)).                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module xorshift32_checker #(
    parameter int unsigned ERR_LIMIT = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             data_valid,
    input  logic [31:0]      data_in,
`ifdef XORSHIFT32_CHECKER_SEED_EN
    input  logic [31:0]      seed,
`endif
    output logic             locked,
    output logic             error_pulse,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    localparam logic [7:0]       c_ERR_LIMIT = 8'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    function automatic logic [31:0] xs_next(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    state_t           state_q;
    logic [31:0]      pred_q;
    logic [7:0]       miss_q;
    logic             locked_q;
    logic             pulse_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] word_cnt_q;

    logic [31:0]      data_next_d;
    logic [7:0]       miss_inc_d;
    logic             hit_d;

    assign data_next_d = xs_next(data_in);
    assign miss_inc_d  = miss_q + 8'd1;
    // Zero is never a legal stream word, even if the predictor itself is zero.
    assign hit_d       = (data_in != 32'd0) && (data_in == pred_q);

`ifdef XORSHIFT32_CHECKER_SEED_EN
    logic [31:0] seed_next_d;
    assign seed_next_d = xs_next(seed);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pred_q     <= 32'd0;
            miss_q     <= 8'd0;
            locked_q   <= 1'b0;
            pulse_q    <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (!enable) begin
                state_q  <= S_IDLE;
                pred_q   <= 32'd0;
                miss_q   <= 8'd0;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
`ifdef XORSHIFT32_CHECKER_SEED_EN
                        pred_q  <= seed_next_d;
                        state_q <= S_CHECK;
`else
                        state_q <= S_ACQUIRE;
`endif
                    end
                    S_ACQUIRE: begin
                        if (data_valid && (data_in != 32'd0)) begin
                            pred_q  <= data_next_d;
                            state_q <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (data_valid) begin
                            // Re-predict from the received word so a single bad word costs two misses.
                            pred_q <= data_next_d;
                            if (word_cnt_q != c_CNT_MAX) begin
                                word_cnt_q <= word_cnt_q + c_CNT_ONE;
                            end
                            if (hit_d) begin
                                miss_q   <= 8'd0;
                                locked_q <= 1'b1;
                            end else begin
                                pulse_q <= 1'b1;
                                if (err_cnt_q != c_CNT_MAX) begin
                                    err_cnt_q <= err_cnt_q + c_CNT_ONE;
                                end
                                if (miss_inc_d >= c_ERR_LIMIT) begin
                                    miss_q   <= 8'd0;
                                    locked_q <= 1'b0;
`ifdef XORSHIFT32_CHECKER_SEED_EN
                                    pred_q   <= seed_next_d;
`else
                                    state_q  <= S_ACQUIRE;
`endif
                                end else begin
                                    miss_q <= miss_inc_d;
                                end
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
            if (clear) begin
                err_cnt_q  <= '0;
                word_cnt_q <= '0;
            end
        end
    end

    assign locked      = locked_q;
    assign error_pulse = pulse_q;
    assign error_count = err_cnt_q;
    assign word_count  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_xorshift32_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_xorshift32_checker                                                    |
// | Self-checking bench: vector table, scoreboard model, stream scenarios.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_xorshift32_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] seed = 32'd123456789;
    logic        locked, error_pulse;
    logic [15:0] error_count, word_count;
    logic        s_locked, s_pulse;
    logic [2:0]  s_ec, s_wc;

    always #5 clk = ~clk;

    xorshift32_checker u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .data_valid(data_valid), .data_in(data_in),
`ifdef XORSHIFT32_CHECKER_SEED_EN
        .seed(seed),
`endif
        .locked(locked), .error_pulse(error_pulse),
        .error_count(error_count), .word_count(word_count)
    );

    xorshift32_checker #(.ERR_LIMIT(1), .CNT_W(3)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .data_valid(data_valid), .data_in(data_in),
`ifdef XORSHIFT32_CHECKER_SEED_EN
        .seed(seed),
`endif
        .locked(s_locked), .error_pulse(s_pulse),
        .error_count(s_ec), .word_count(s_wc)
    );

    typedef struct {
        int          st;     // 0 idle, 1 acquire, 2 check
        logic [31:0] pred;
        int          miss;
        logic        lk;
        logic        pl;
        int          ec;
        int          wc;
    } m_t;

    typedef struct packed {
        logic        lk, pl;
        logic [15:0] ec, wc;
        logic        slk, spl;
        logic [2:0]  sec, swc;
    } exp_t;

    typedef struct {
        logic rn, en, clr, v;
        logic [31:0] d;
        logic lk, pl;
        int ec, wc;
    } vec_t;

    m_t   mm, ms;
    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] a, b;
        a = x ^ (x << 13);
        b = a ^ (a >> 17);
        return b ^ (b << 5);
    endfunction

    function automatic m_t mstep(input m_t s, input logic rn, en, clr, v,
                                 input logic [31:0] d, sd, input int lim, maxc);
        m_t n;
        n = s;
        n.pl = 1'b0;
        if (!rn) begin
            n.st = 0; n.pred = 0; n.miss = 0; n.lk = 0; n.ec = 0; n.wc = 0;
            return n;
        end
        if (!en) begin
            n.st = 0; n.lk = 0; n.miss = 0; n.pred = 0;
        end else if (s.st == 0) begin
`ifdef XORSHIFT32_CHECKER_SEED_EN
            n.pred = xs(sd); n.st = 2;
`else
            n.st = 1;
`endif
        end else if (s.st == 1) begin
            if (v && d != 0) begin n.pred = xs(d); n.st = 2; end
        end else if (v) begin
            n.wc   = (s.wc < maxc) ? s.wc + 1 : maxc;
            n.pred = xs(d);
            if (d != 0 && d == s.pred) begin
                n.miss = 0; n.lk = 1;
            end else begin
                n.pl   = 1;
                n.ec   = (s.ec < maxc) ? s.ec + 1 : maxc;
                n.miss = s.miss + 1;
                if (n.miss >= lim) begin
                    n.miss = 0; n.lk = 0;
`ifdef XORSHIFT32_CHECKER_SEED_EN
                    n.pred = xs(sd);
`else
                    n.st = 1;
`endif
                end
            end
        end
        if (clr) begin n.ec = 0; n.wc = 0; end
        return n;
    endfunction

    task automatic step(input logic rn, en, clr, v, input logic [31:0] d);
        exp_t e, a;
        rst_n = rn; enable = en; clear = clr; data_valid = v; data_in = d;
        mm = mstep(mm, rn, en, clr, v, d, seed, 4, 65535);
        ms = mstep(ms, rn, en, clr, v, d, seed, 1, 7);
        sbq.push_back('{mm.lk, mm.pl, 16'(mm.ec), 16'(mm.wc),
                        ms.lk, ms.pl, 3'(ms.ec), 3'(ms.wc)});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        a = '{locked, error_pulse, error_count, word_count, s_locked, s_pulse, s_ec, s_wc};
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t got lk=%b pl=%b ec=%0d wc=%0d s:%b %b %0d %0d expected lk=%b pl=%b ec=%0d wc=%0d s:%b %b %0d %0d",
                     $time, a.lk, a.pl, a.ec, a.wc, a.slk, a.spl, a.sec, a.swc,
                     e.lk, e.pl, e.ec, e.wc, e.slk, e.spl, e.sec, e.swc);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic restart();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic run_stream(input logic [31:0] x0, input int n, input int flip,
                              input bit gaps, output int pulses, output int drops);
        logic [31:0] w;
        w = x0; pulses = 0; drops = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) step(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
            end
            step(1'b1, 1'b1, 1'b0, 1'b1, (i == flip) ? (w ^ 32'h1) : w);
            pulses += int'(error_pulse);
            if (i >= 1 && !locked) drops++;
            w = xs(w);
        end
    endtask

    initial begin
        int   pulses, drops, nlock;
        logic [31:0] w;
`ifndef XORSHIFT32_CHECKER_SEED_EN
        vec_t tbl[13];
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h075BCD15, 1'b0, 1'b0, 0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA1D31F49, 1'b1, 1'b0, 0, 1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0, 0, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 1, 2};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 2, 3};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 0, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h5,        1'b0, 1'b1, 1, 1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h075BCD15, 1'b0, 1'b0, 1, 1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA1D31F49, 1'b1, 1'b0, 1, 2};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000000A, 1'b0, 1'b0, 1, 2};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rn, tbl[i].en, tbl[i].clr, tbl[i].v, tbl[i].d);
            n_chk++;
            if (locked !== tbl[i].lk || error_pulse !== tbl[i].pl ||
                int'(error_count) != tbl[i].ec || int'(word_count) != tbl[i].wc) begin
                n_fail++;
                $display("FAIL vector[%0d] got lk=%b pl=%b ec=%0d wc=%0d expected lk=%b pl=%b ec=%0d wc=%0d",
                         i, locked, error_pulse, error_count, word_count,
                         tbl[i].lk, tbl[i].pl, tbl[i].ec, tbl[i].wc);
            end
        end

        // Clean self-synchronising stream
        restart();
        run_stream(32'h075BCD15, 100, -1, 1'b0, pulses, drops);
        chk("clean_err", int'(error_count), 0);
        chk("clean_words", int'(word_count), 99);
        chk("clean_lock_drops", drops, 0);
        chk("clean_small_words_sat", int'(s_wc), 7);

        // Single bit flip at word 10
        restart();
        run_stream(32'h075BCD15, 100, 9, 1'b0, pulses, drops);
        chk("flip_pulses", pulses, 2);
        chk("flip_err", int'(error_count), 2);
        chk("flip_lock_drops", drops, 0);
        chk("flip_words", int'(word_count), 99);

        // Constant garbage
        restart();
        nlock = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
            nlock += int'(locked);
            if (i % 5 == 4) chk("garbage_err", int'(error_count), 4 * (i / 5 + 1));
        end
        chk("garbage_lock", nlock, 0);
        chk("garbage_small_err_sat", int'(s_ec), 7);

        // Leading zeros and random gaps
        restart();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
        run_stream(32'h075BCD15, 30, -1, 1'b1, pulses, drops);
        chk("gaps_err", int'(error_count), 0);
        chk("gaps_words", int'(word_count), 29);
        chk("gaps_lock_drops", drops, 0);

        // Reset at word 50, enable drop at word 70
        restart();
        w = 32'h075BCD15;
        for (int i = 0; i < 100; i++) begin
            step((i == 50) ? 1'b0 : 1'b1, (i == 70) ? 1'b0 : 1'b1, 1'b0, 1'b1, w);
            if (i == 50) chk("midreset_outputs",
                             int'({locked, error_pulse, error_count, word_count}), 0);
            if (i == 70) begin
                chk("midenable_locked", int'(locked), 0);
                chk("midenable_words", int'(word_count), 17);
            end
            w = xs(w);
        end
        chk("resync_locked", int'(locked), 1);
        chk("resync_words", int'(word_count), 44);
        chk("resync_err", int'(error_count), 0);
`else
        seed = 32'd123456789;
        restart();
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hA1D31F49);
        chk("seed_locked", int'(locked), 1);
        chk("seed_words", int'(word_count), 1);
        chk("seed_err", int'(error_count), 0);
        restart();
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678);
        chk("seed_bad_err", int'(error_count), 1);
        chk("seed_bad_words", int'(word_count), 1);
        restart();
        run_stream(32'hA1D31F49, 20, -1, 1'b1, pulses, drops);
        chk("seed_stream_err", int'(error_count), 0);
        chk("seed_stream_words", int'(word_count), 20);
        chk("seed_stream_drops", drops, 0);
        seed = 32'd0;
        restart();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
        chk("seed_zero_err", int'(error_count), 3);
        chk("seed_zero_locked", int'(locked), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
